// File: rtl/mem_arbiter_if.sv
// Bundle of request, response and memory-side signals for mem_arbiter.
// The arbiter binds the slave modport; the environment driving the
// fetch unit, the load/store unit and the backing memory binds master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  // instruction-fetch port
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  // load/store port
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_wen;
  logic [DATA_W-1:0] ls_wdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;

  // backing-memory port
  logic              mem_req;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_req, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_req, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (IF) and load/store (LS)
// share one backing memory with a single outstanding transaction.
// ARB_MODE=0 gives LS fixed priority, ARB_MODE=1 alternates on ties.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_ls_q, owner_ls_d;   // 1: LS owns the transaction
  logic              last_ls_q, last_ls_d;     // 1: last grant went to LS
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic grant_ls;
  logic if_ready;
  logic ls_ready;

  // Arbitration: pick a winner among valid requesters; readies only in IDLE
  // and never while reset is held, so nothing is accepted during reset.
  always_comb begin
    grant_ls = 1'b0;
    if (bus.ls_req_valid && bus.if_req_valid) begin
      grant_ls = (ARB_MODE == 0) ? 1'b1 : !last_ls_q;
    end else begin
      grant_ls = bus.ls_req_valid;
    end
    ls_ready = (state_q == ST_IDLE) && !rst && bus.ls_req_valid && grant_ls;
    if_ready = (state_q == ST_IDLE) && !rst && bus.if_req_valid && !grant_ls;
  end

  // Next-state logic: capture the accepted request, then walk it through
  // memory issue, response wait and a single response cycle.
  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    last_ls_d  = last_ls_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ls_ready) begin
          state_d    = ST_ISSUE;
          owner_ls_d = 1'b1;
          last_ls_d  = 1'b1;
          addr_d     = bus.ls_addr;
          wen_d      = bus.ls_wen;
          wdata_d    = bus.ls_wdata;
          wmask_d    = bus.ls_wmask;
        end else if (if_ready) begin
          // fetches are always reads: no write enable, no byte mask
          state_d    = ST_ISSUE;
          owner_ls_d = 1'b0;
          last_ls_d  = 1'b0;
          addr_d     = bus.if_addr;
          wen_d      = 1'b0;
          wdata_d    = '0;
          wmask_d    = '0;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = ST_RESP;
          // the memory acknowledges stores with rvalid; their data reads as 0
          rdata_d = wen_q ? '0 : bus.mem_rdata;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_ls_q <= 1'b0;
      last_ls_q  <= 1'b1;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      last_ls_q  <= last_ls_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.if_req_ready = if_ready;
  assign bus.ls_req_ready = ls_ready;

  // memory side is driven purely from the captured request registers
  assign bus.mem_req   = (state_q == ST_ISSUE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;

  // only the owner sees a response; data is zero outside its pulse
  assign bus.if_rsp_valid = (state_q == ST_RESP) && !owner_ls_q;
  assign bus.ls_rsp_valid = (state_q == ST_RESP) && owner_ls_q;
  assign bus.if_rsp_data  = bus.if_rsp_valid ? rdata_q : '0;
  assign bus.ls_rsp_data  = bus.ls_rsp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one fixed-priority and one round-robin instance,
// exercised one at a time from shared stimulus, checked against a
// transaction-level model of grants, memory fields, latency and responses.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   sel = 1'b0;   // 0: fixed-priority instance, 1: round-robin instance

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // stimulus; the unselected instance sees no valid/ready/rvalid
  logic          t_if_v = 1'b0, t_ls_v = 1'b0;
  logic [AW-1:0] t_if_addr = '0, t_ls_addr = '0;
  logic          t_ls_wen = 1'b0;
  logic [DW-1:0] t_ls_wdata = '0;
  logic [MW-1:0] t_ls_wmask = '0;
  logic          t_mem_ready = 1'b0, t_mem_rvalid = 1'b0;
  logic [DW-1:0] t_mem_rdata = '0;

  assign bus0.if_req_valid = t_if_v & !sel;
  assign bus0.if_addr      = t_if_addr;
  assign bus0.ls_req_valid = t_ls_v & !sel;
  assign bus0.ls_addr      = t_ls_addr;
  assign bus0.ls_wen       = t_ls_wen;
  assign bus0.ls_wdata     = t_ls_wdata;
  assign bus0.ls_wmask     = t_ls_wmask;
  assign bus0.mem_ready    = t_mem_ready & !sel;
  assign bus0.mem_rvalid   = t_mem_rvalid & !sel;
  assign bus0.mem_rdata    = t_mem_rdata;

  assign bus1.if_req_valid = t_if_v & sel;
  assign bus1.if_addr      = t_if_addr;
  assign bus1.ls_req_valid = t_ls_v & sel;
  assign bus1.ls_addr      = t_ls_addr;
  assign bus1.ls_wen       = t_ls_wen;
  assign bus1.ls_wdata     = t_ls_wdata;
  assign bus1.ls_wmask     = t_ls_wmask;
  assign bus1.mem_ready    = t_mem_ready & sel;
  assign bus1.mem_rvalid   = t_mem_rvalid & sel;
  assign bus1.mem_rdata    = t_mem_rdata;

  // observed outputs of the selected instance
  logic          o_if_ready, o_ls_ready, o_if_rsp_valid, o_ls_rsp_valid;
  logic          o_mem_req, o_mem_wen;
  logic [DW-1:0] o_if_rsp_data, o_ls_rsp_data, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [MW-1:0] o_mem_wmask;

  assign o_if_ready     = sel ? bus1.if_req_ready : bus0.if_req_ready;
  assign o_ls_ready     = sel ? bus1.ls_req_ready : bus0.ls_req_ready;
  assign o_if_rsp_valid = sel ? bus1.if_rsp_valid : bus0.if_rsp_valid;
  assign o_ls_rsp_valid = sel ? bus1.ls_rsp_valid : bus0.ls_rsp_valid;
  assign o_if_rsp_data  = sel ? bus1.if_rsp_data  : bus0.if_rsp_data;
  assign o_ls_rsp_data  = sel ? bus1.ls_rsp_data  : bus0.ls_rsp_data;
  assign o_mem_req      = sel ? bus1.mem_req      : bus0.mem_req;
  assign o_mem_wen      = sel ? bus1.mem_wen      : bus0.mem_wen;
  assign o_mem_addr     = sel ? bus1.mem_addr     : bus0.mem_addr;
  assign o_mem_wdata    = sel ? bus1.mem_wdata    : bus0.mem_wdata;
  assign o_mem_wmask    = sel ? bus1.mem_wmask    : bus0.mem_wmask;

  // reference model state: pending requests and last grant per instance
  bit p_if = 1'b0, p_ls = 1'b0;
  bit m_last_ls [2] = '{1'b1, 1'b1};

  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s mode=%0d observed=0x%0h expected=0x%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic check_rst_outs(input string pfx);
    check({pfx, "_if_ready"},     o_if_ready, 0);
    check({pfx, "_ls_ready"},     o_ls_ready, 0);
    check({pfx, "_if_rsp_valid"}, o_if_rsp_valid, 0);
    check({pfx, "_ls_rsp_valid"}, o_ls_rsp_valid, 0);
    check({pfx, "_mem_req"},      o_mem_req, 0);
    check({pfx, "_mem_wen"},      o_mem_wen, 0);
    check({pfx, "_mem_wmask"},    o_mem_wmask, 0);
    check({pfx, "_mem_addr"},     o_mem_addr, 0);
    check({pfx, "_mem_wdata"},    o_mem_wdata, 0);
    check({pfx, "_if_rsp_data"},  o_if_rsp_data, 0);
    check({pfx, "_ls_rsp_data"},  o_ls_rsp_data, 0);
  endtask

  // both instances are held in reset; inspect each in turn
  task automatic check_rst_both(input string pfx);
    bit keep;
    keep = sel;
    sel = 1'b0; #1; check_rst_outs({pfx, "0"});
    sel = 1'b1; #1; check_rst_outs({pfx, "1"});
    sel = keep; #1;
  endtask

  // create new requests for idle requesters; force_both makes both pending
  task automatic gen_pending(input bit force_both);
    if (!p_if && (force_both || $urandom_range(0, 1) == 1)) begin
      p_if = 1'b1;
      t_if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!p_ls && (force_both || $urandom_range(0, 1) == 1)) begin
      p_ls = 1'b1;
      t_ls_addr  = $urandom;
      t_ls_wen   = 1'($urandom_range(0, 1));
      t_ls_wdata = $urandom;
      t_ls_wmask = 4'($urandom_range(0, 15));
    end
    if (!p_if && !p_ls) begin
      p_if = 1'b1;
      t_if_addr = $urandom & 32'hFFFF_FFFC;
    end
  endtask

  // One complete transaction, entered at a falling edge with at least one
  // request pending. rdy_dly/rv_dly: stall cycles before mem_ready/mem_rvalid.
  task automatic run_txn(input int rdy_dly, input int rv_dly, input logic [DW-1:0] rdata);
    bit            g_ls;
    logic [AW-1:0] e_addr;
    logic          e_wen;
    logic [DW-1:0] e_wdata, e_rsp;
    logic [MW-1:0] e_wmask;
    if (p_if && p_ls) g_ls = (sel == 1'b0) ? 1'b1 : !m_last_ls[sel];
    else              g_ls = p_ls;
    if (g_ls) begin
      e_addr = t_ls_addr; e_wen = t_ls_wen; e_wdata = t_ls_wdata; e_wmask = t_ls_wmask;
    end else begin
      e_addr = t_if_addr; e_wen = 1'b0; e_wdata = '0; e_wmask = '0;
    end
    e_rsp = (g_ls && e_wen) ? '0 : rdata;

    t_if_v = p_if; t_ls_v = p_ls; t_mem_ready = 1'b0; t_mem_rvalid = 1'b0;
    #1;
    check("grant_if_ready", o_if_ready, !g_ls);
    check("grant_ls_ready", o_ls_ready, g_ls);
    $display("txn mode=%0d grant=%s addr=0x%08h wen=%0d rdy_dly=%0d rv_dly=%0d exp_rsp=0x%08h",
             sel, g_ls ? "LS" : "IF", e_addr, e_wen, rdy_dly, rv_dly, e_rsp);
    @(posedge clk);
    m_last_ls[sel] = g_ls;
    if (g_ls) p_ls = 1'b0; else p_if = 1'b0;
    @(negedge clk);
    t_if_v = p_if; t_ls_v = p_ls;

    // issue: request held with stable fields until mem_ready; rvalid is noise
    for (int i = 0; i <= rdy_dly; i++) begin
      t_mem_ready  = (i == rdy_dly);
      t_mem_rvalid = 1'($urandom_range(0, 1));
      t_mem_rdata  = $urandom;
      #1;
      check("issue_mem_req", o_mem_req, 1);
      check("issue_addr", o_mem_addr, e_addr);
      check("issue_wen", o_mem_wen, e_wen);
      check("issue_wmask", o_mem_wmask, e_wmask);
      if (g_ls) check("issue_wdata", o_mem_wdata, e_wdata);
      check("issue_no_ready", {o_if_ready, o_ls_ready}, 0);
      check("issue_no_rsp", {o_if_rsp_valid, o_ls_rsp_valid}, 0);
      @(negedge clk);
    end

    // wait: mem_ready is noise, response only after rvalid
    for (int i = 0; i <= rv_dly; i++) begin
      t_mem_ready  = 1'($urandom_range(0, 1));
      t_mem_rvalid = (i == rv_dly);
      t_mem_rdata  = (i == rv_dly) ? rdata : $urandom;
      #1;
      check("wait_mem_req", o_mem_req, 0);
      check("wait_no_ready", {o_if_ready, o_ls_ready}, 0);
      check("wait_no_rsp", {o_if_rsp_valid, o_ls_rsp_valid}, 0);
      @(negedge clk);
    end

    // response cycle
    t_mem_ready  = 1'($urandom_range(0, 1));
    t_mem_rvalid = 1'($urandom_range(0, 1));
    t_mem_rdata  = $urandom;
    #1;
    check("rsp_if_valid", o_if_rsp_valid, !g_ls);
    check("rsp_ls_valid", o_ls_rsp_valid, g_ls);
    check("rsp_data", g_ls ? o_ls_rsp_data : o_if_rsp_data, e_rsp);
    check("rsp_no_ready", {o_if_ready, o_ls_ready}, 0);
    check("rsp_mem_req", o_mem_req, 0);
    @(negedge clk);
    t_mem_ready = 1'b0; t_mem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // reset held with every input asserted: nothing may leak out
    t_if_v = 1'b1; t_ls_v = 1'b1; t_mem_ready = 1'b1; t_mem_rvalid = 1'b1;
    t_mem_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check_rst_both("reset");
    rst = 1'b0;
    t_if_v = 1'b0; t_ls_v = 1'b0; t_mem_ready = 1'b0; t_mem_rvalid = 1'b0;

    // ---- fixed priority instance ----
    sel = 1'b0;
    // fetch with earliest memory handshake, accepted on first edge after reset
    p_if = 1'b1; t_if_addr = 32'h8000_0000;
    run_txn(0, 0, 32'h0010_0093);
    // store, then a fetch that must carry a zero mask
    p_ls = 1'b1; t_ls_addr = 32'h8000_1000; t_ls_wen = 1'b1;
    t_ls_wdata = 32'hDEAD_BEEF; t_ls_wmask = 4'hF;
    run_txn(0, 0, 32'h5555_AAAA);
    p_if = 1'b1; t_if_addr = 32'h8000_0004;
    run_txn(0, 1, 32'h0020_0113);
    // both requesters valid every cycle: LS always wins
    for (int k = 0; k < 6; k++) begin
      gen_pending(1'b1);
      run_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end
    while (p_if || p_ls) run_txn(0, 0, $urandom);
    // long memory stall with the other requester waiting
    p_ls = 1'b1; t_ls_addr = 32'h8000_2000; t_ls_wen = 1'b0;
    t_ls_wdata = 32'h0; t_ls_wmask = 4'h0;
    p_if = 1'b1; t_if_addr = 32'h8000_0100;
    run_txn(5, 2, 32'hCAFE_F00D);
    while (p_if || p_ls) run_txn(0, 0, $urandom);

    // reset during WAIT, then a stale rvalid must produce nothing
    p_if = 1'b1; t_if_addr = 32'h8000_0040; t_if_v = 1'b1;
    #1; check("abort_accept", o_if_ready, 1);
    @(negedge clk); p_if = 1'b0; t_if_v = 1'b0; t_mem_ready = 1'b1;
    @(negedge clk); t_mem_ready = 1'b0;
    #1; check("abort_in_wait", o_mem_req, 0);
    t_if_v = 1'b1; t_ls_v = 1'b1;
    rst = 1'b1;
    check_rst_both("midreset");
    @(negedge clk);
    rst = 1'b0; t_if_v = 1'b0; t_ls_v = 1'b0;
    m_last_ls[0] = 1'b1; m_last_ls[1] = 1'b1;
    t_mem_rvalid = 1'b1; t_mem_rdata = 32'hBAD0_BAD0;
    #1; check("stale_rvalid_no_rsp0", {o_if_rsp_valid, o_ls_rsp_valid}, 0);
    @(negedge clk); t_mem_rvalid = 1'b0;
    #1; check("stale_rvalid_no_rsp1", {o_if_rsp_valid, o_ls_rsp_valid}, 0);
    check("stale_rvalid_no_req", o_mem_req, 0);
    @(negedge clk);
    p_ls = 1'b1; t_ls_addr = 32'h8000_3000; t_ls_wen = 1'b0;
    run_txn(0, 0, 32'h7777_0001);

    // randomized traffic, fixed priority
    for (int k = 0; k < 40; k++) begin
      gen_pending(1'b0);
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    while (p_if || p_ls) run_txn(0, 0, $urandom);

    // ---- round-robin instance ----
    sel = 1'b1;
    // both valid every cycle: IF, LS, IF, LS ...
    for (int k = 0; k < 8; k++) begin
      gen_pending(1'b1);
      run_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end
    while (p_if || p_ls) run_txn(0, 0, $urandom);
    for (int k = 0; k < 40; k++) begin
      gen_pending(1'b0);
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    while (p_if || p_ls) run_txn(0, 0, $urandom);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 ADDR_W, default 32, address width of all ports.
REQ-002 DATA_W, default 32, data width of all ports; legal values are multiples of 8.
REQ-003 ARB_MODE, default 0; 0 = fixed priority (LSU over IF), 1 = round-robin.

Interface
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 if_req_valid  in  1  fetch request present.
REQ-007 if_req_ready  out  1  fetch request accepted this cycle.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 if_rsp_valid  out  1  one-cycle pulse; fetch data valid.
REQ-010 if_rsp_data  out  DATA_W  fetch data.
REQ-011 ls_req_valid  in  1  load/store request present.
REQ-012 ls_req_ready  out  1  load/store request accepted this cycle.
REQ-013 ls_addr / ls_wen / ls_wdata / ls_wmask  in  ADDR_W / 1 / DATA_W / DATA_W/8  LSU request fields.
REQ-014 ls_rsp_valid  out  1  one-cycle pulse; load data, or store completion.
REQ-015 ls_rsp_data  out  DATA_W  load data; 0 for stores.
REQ-016 mem_req  out  1  backing-memory request.
REQ-017 mem_ready  in  1  memory accepts mem_req this cycle.
REQ-018 mem_addr / mem_wen / mem_wdata / mem_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  registered request fields.
REQ-019 mem_rvalid  in  1  memory response valid; arbitrary latency of at least 1 cycle after acceptance.
REQ-020 mem_rdata  in  DATA_W  memory response data.

Function
REQ-021 A request transfers on the rising edge where valid and ready are both 1; a requester holds its fields stable while valid=1 and ready=0.
REQ-022 At most one transaction is outstanding at any time.
REQ-023 FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE when a request is accepted.
- ISSUE -> WAIT when mem_ready=1.
- WAIT -> RESP when mem_rvalid=1.
- RESP -> IDLE unconditionally.
REQ-024 if_req_ready and ls_req_ready are asserted only in IDLE, and never both in the same cycle.
REQ-025 On acceptance, the request fields and an owner flag (IF or LS) are registered; mem_* outputs are driven only from these registers.
REQ-026 mem_req=1 only in ISSUE; mem_req stays high with fields stable until mem_ready=1.
REQ-027 For an IF-owned transaction, mem_wen=0 and mem_wmask=0.
REQ-028 In WAIT, mem_rdata is captured when mem_rvalid=1.
REQ-029 In RESP, exactly the owner's rsp_valid pulses for one cycle, with the captured data.
REQ-030 Minimum latency from acceptance to rsp_valid is 3 cycles (mem_ready and mem_rvalid each at their earliest cycle).
REQ-031 mem_rvalid outside WAIT is ignored.
REQ-032 mem_ready outside ISSUE is ignored.
REQ-033 Arbitration when both requests are valid in IDLE:
- ARB_MODE=0: LS is granted.
- ARB_MODE=1: the requester not granted last is granted; the last-grant register resets to LS, so IF wins the first tie.
REQ-034 A single valid requester is granted regardless of ARB_MODE.
REQ-035 A store receives ls_rsp_valid with ls_rsp_data=0 after mem_rvalid; the memory acknowledges stores via mem_rvalid.
REQ-036 Requests arriving while not in IDLE wait and are not lost; the handshake does not complete until ready.

Reset
REQ-037 While rst=1, the FSM is in IDLE and the following are 0: all ready outputs, all rsp_valid outputs, mem_req, mem_wen, mem_wmask, and all data/address outputs. The last-grant register holds LS.
REQ-038 rst asserted mid-transaction aborts the transaction; no response is issued and any late mem_rvalid after reset release is ignored (FSM in IDLE).
REQ-039 After rst falls, the first acceptance can occur on the first rising edge.

Verification
REQ-040 IF fetch addr 0x80000000, mem_ready immediate, mem_rvalid one cycle later with 0x00100093 -> if_rsp_valid pulse with data 0x00100093, 3 cycles after acceptance; ls_rsp_valid stays 0.
REQ-041 LS store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> mem_wen=1 and fields match; ls_rsp_valid with data 0; mem_wmask=0 on a subsequent IF fetch.
REQ-042 Both requesters valid every cycle, ARB_MODE=0 -> LS granted every time; IF is never granted while ls_req_valid stays high.
REQ-043 Both requesters valid every cycle, ARB_MODE=1 -> grants alternate IF, LS, IF, LS; exactly one ready per cycle.
REQ-044 mem_ready held low for 5 cycles -> mem_req and fields stable for all 5 cycles; no new request accepted meanwhile.
REQ-045 rst pulsed during WAIT, then mem_rvalid=1 -> no rsp_valid; next request completes normally.
